// File: rtl/sync_sender_pkg.sv
// sync_sender_pkg: shared FSM encoding and sticky error-bit constants for sync_sender
package sync_sender_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT} state_t;
  localparam logic O_ERR_CLEAR = 1'b0;
  localparam logic O_ERR_SET = 1'b1;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: reset-to-zero flop chain synchroniser for one asynchronous bit
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk) sr <= rst ? '0 : {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/sync_sender.sv
// sync_sender: FIFO-buffered two-phase bundled-data request source with synchronised ack
module sync_sender
  import sync_sender_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_data,
  output logic                    outR,
  input  logic                    outA,
  output logic [DATA_W-1:0]       o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_err
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic ack_s, push, pop;
  bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (.clk(clk), .rst(rst), .d(outA), .q(ack_s));
  assign o_ready = o_count != (AW+1)'(DEPTH);
  assign push = i_valid & o_ready;
  assign pop = (state == S_WAIT) & (ack_s == outR);
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= i_data;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_count <= '0;
      outR <= 1'b0;
      o_data <= '0;
      o_err <= O_ERR_CLEAR;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      o_count <= o_count + (AW+1)'(push) - (AW+1)'(pop);
      if (state != S_WAIT && ack_s != outR) o_err <= O_ERR_SET;
      case (state)
        S_IDLE:
          if (o_count != '0) begin
            o_data <= mem[rd_ptr];
            state <= S_SETUP;
          end
        S_SETUP: begin
          outR <= ~outR;
          state <= S_WAIT;
        end
        S_WAIT: if (pop) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sync_sender.sv
// tb_sync_sender: directed and scoreboard checks of sync_sender against a delayed-echo ack model
module tb_sync_sender;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic o_ready;
  logic [31:0] i_data = '0;
  logic out_r;
  logic out_a;
  logic [31:0] o_data;
  logic [2:0] o_count;
  logic o_err;
  logic ack_q, ack_hold = 1'b0, flip = 1'b0, rand_mode = 1'b0;
  int ack_cnt, ack_tgt, bd_viol = 0;
  logic prev_diff = 1'b0;
  logic [31:0] prev_d = '0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign out_a = ack_q ^ flip;
  sync_sender dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .outR(out_r), .outA(out_a), .o_data(o_data), .o_count(o_count), .o_err(o_err)
  );
  always @(posedge clk)
    if (rst) begin
      ack_q <= 1'b0;
      ack_cnt <= 0;
      ack_tgt <= 0;
    end else if (!ack_hold && out_r != ack_q) begin
      if (ack_cnt >= ack_tgt) begin
        ack_q <= out_r;
        ack_cnt <= 0;
        ack_tgt <= rand_mode ? int'($urandom_range(20, 0)) : 0;
      end else ack_cnt <= ack_cnt + 1;
    end
  always @(negedge clk) begin
    if (!rst && prev_diff && (out_r != out_a) && o_data !== prev_d) bd_viol <= bd_viol + 1;
    prev_diff <= !rst && (out_r != out_a);
    prev_d <= o_data;
  end
  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    flip = 1'b0;
    ack_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    vectors++; if (out_r !== 1'b0) begin miscompares++; $display("FAIL reset_outR: got %b want 0", out_r); end
    vectors++; if (o_data !== 32'h0) begin miscompares++; $display("FAIL reset_o_data: got %h want 0", o_data); end
    vectors++; if (o_count !== 3'd0) begin miscompares++; $display("FAIL reset_o_count: got %0d want 0", o_count); end
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset_o_err: got %b want 0", o_err); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
  endtask
  task automatic test_single();
    int cyc;
    logic stable;
    @(negedge clk); i_valid = 1'b1; i_data = 32'hA5A5_0001;
    @(negedge clk); i_valid = 1'b0;
    vectors++; if (o_count !== 3'd1) begin miscompares++; $display("FAIL single_count_after_push: got %0d want 1", o_count); end
    @(negedge clk);
    vectors++; if (o_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL single_setup_data: got %h want a5a50001", o_data); end
    vectors++; if (out_r !== 1'b0) begin miscompares++; $display("FAIL single_outR_early: got %b want 0", out_r); end
    @(negedge clk);
    vectors++; if (out_r !== 1'b1) begin miscompares++; $display("FAIL single_outR_rise: got %b want 1", out_r); end
    stable = (o_data === 32'hA5A5_0001);
    cyc = 0;
    while (o_count !== 3'd0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (o_data !== 32'hA5A5_0001) stable = 1'b0;
    end
    vectors++; if (!stable) begin miscompares++; $display("FAIL single_data_stable: got unstable want %h held", 32'hA5A5_0001); end
    vectors++; if (cyc != 4) begin miscompares++; $display("FAIL single_pop_latency: got %0d want 4 cycles", cyc); end
    vectors++; if (o_count !== 3'd0) begin miscompares++; $display("FAIL single_count_after_pop: got %0d want 0", o_count); end
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b want 0", o_err); end
  endtask
  task automatic test_full();
    logic [31:0] w [6];
    logic prev_r;
    int ntog;
    do_reset();
    ack_hold = 1'b1;
    for (int k = 0; k < 6; k++) w[k] = 32'hC0DE_0000 + 32'(k);
    prev_r = out_r;
    ntog = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_r !== prev_r) begin
        vectors++;
        if (ntog >= 4) begin
          miscompares++; $display("FAIL full_extra_toggle: got toggle %0d want 4 toggles", ntog + 1);
        end else if (o_data !== w[ntog] || out_r !== ~ntog[0]) begin
          miscompares++; $display("FAIL full_order: got %h/%b want %h/%b", o_data, out_r, w[ntog], ~ntog[0]);
        end
        ntog++;
        prev_r = out_r;
      end
      if (c == 3) begin
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_before_4th: got %b want 1", o_ready); end
      end
      if (c == 4) begin
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_after_4th: got %b want 0", o_ready); end
        vectors++; if (o_count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", o_count); end
      end
      if (c == 11) begin
        vectors++; if (o_count !== 3'd4) begin miscompares++; $display("FAIL full_overflow_ignored: got %0d want 4", o_count); end
      end
      if (c < 6) begin
        i_valid = 1'b1;
        i_data = w[c];
      end else i_valid = 1'b0;
      if (c == 12) ack_hold = 1'b0;
    end
    vectors++; if (ntog != 4) begin miscompares++; $display("FAIL full_toggle_count: got %0d want 4", ntog); end
    vectors++; if (o_count !== 3'd0) begin miscompares++; $display("FAIL full_drain: got %0d want 0", o_count); end
    vectors++; if (out_r !== 1'b0) begin miscompares++; $display("FAIL full_final_phase: got %b want 0", out_r); end
  endtask
  task automatic test_simul();
    logic [31:0] w [10];
    logic prev_r;
    int ntog, nxt, chk_at, c;
    do_reset();
    for (int k = 0; k < 10; k++) w[k] = 32'h5100_0000 + 32'(k * 3);
    prev_r = out_r;
    ntog = 0;
    nxt = 2;
    chk_at = -1;
    c = 0;
    while (!(ntog == 10 && o_count === 3'd0) && c < 200) begin
      @(negedge clk);
      if (c == chk_at) begin
        vectors++; if (o_count !== 3'd2) begin miscompares++; $display("FAIL simul_count: got %0d want 2", o_count); end
      end
      i_valid = 1'b0;
      if (out_r !== prev_r) begin
        vectors++;
        if (ntog >= 10 || o_data !== w[ntog]) begin
          miscompares++; $display("FAIL simul_order: got %h at word %0d", o_data, ntog);
        end
        ntog++;
        prev_r = out_r;
        if (nxt < 10) chk_at = c + 4;
      end
      if (c < 2) begin
        i_valid = 1'b1;
        i_data = w[c];
      end else if (c == chk_at - 1 && nxt < 10) begin
        i_valid = 1'b1;
        i_data = w[nxt];
        nxt++;
      end
      c++;
    end
    i_valid = 1'b0;
    vectors++; if (ntog != 10) begin miscompares++; $display("FAIL simul_words: got %0d want 10", ntog); end
    vectors++; if (o_count !== 3'd0) begin miscompares++; $display("FAIL simul_drain: got %0d want 0", o_count); end
  endtask
  task automatic test_err();
    do_reset();
    @(negedge clk); flip = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", o_err); end
    flip = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (o_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", o_err); end
    vectors++; if (out_r !== 1'b0 || o_count !== 3'd0) begin miscompares++; $display("FAIL err_fsm_idle: got %b/%0d want 0/0", out_r, o_count); end
    do_reset();
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b want 0", o_err); end
  endtask
  task automatic test_reset_mid();
    int cyc;
    do_reset();
    ack_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); i_valid = 1'b1; i_data = 32'hBEEF_0000 + 32'(k);
    end
    @(negedge clk); i_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (out_r !== 1'b1 || o_count !== 3'd3) begin miscompares++; $display("FAIL mid_wait_state: got %b/%0d want 1/3", out_r, o_count); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (out_r !== 1'b0) begin miscompares++; $display("FAIL mid_outR: got %b want 0", out_r); end
    vectors++; if (o_data !== 32'h0) begin miscompares++; $display("FAIL mid_o_data: got %h want 0", o_data); end
    vectors++; if (o_count !== 3'd0) begin miscompares++; $display("FAIL mid_o_count: got %0d want 0", o_count); end
    vectors++; if (o_ready !== 1'b1 || o_err !== 1'b0) begin miscompares++; $display("FAIL mid_ready_err: got %b/%b want 1/0", o_ready, o_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    @(negedge clk); i_valid = 1'b1; i_data = 32'h1234_5678;
    @(negedge clk); i_valid = 1'b0;
    cyc = 0;
    while (out_r !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++; if (out_r !== 1'b1 || o_data !== 32'h1234_5678) begin miscompares++; $display("FAIL mid_new_word: got %b/%h want 1/12345678", out_r, o_data); end
    cyc = 0;
    while (o_count !== 3'd0 && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++; if (o_count !== 3'd0 || o_err !== 1'b0) begin miscompares++; $display("FAIL mid_complete: got %0d/%b want 0/0", o_count, o_err); end
  endtask
  task automatic test_random();
    logic [31:0] sb [$];
    logic [31:0] nxt, exp;
    logic prev_r;
    int sent, recv, c;
    do_reset();
    rand_mode = 1'b1;
    prev_r = out_r;
    nxt = 32'h7000_0000;
    sent = 0;
    recv = 0;
    c = 0;
    while (recv < 1000 && c < 60000) begin
      @(negedge clk);
      if (out_r !== prev_r) begin
        prev_r = out_r;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL random_unexpected: got %h want none", o_data);
        end else begin
          exp = sb.pop_front();
          if (o_data !== exp) begin miscompares++; $display("FAIL random_order: got %h want %h", o_data, exp); end
        end
        recv++;
      end
      i_valid = 1'b0;
      if (sent < 1000 && $urandom_range(3, 0) != 0) begin
        i_valid = 1'b1;
        i_data = nxt;
        if (o_ready === 1'b1) begin
          sb.push_back(nxt);
          nxt = nxt * 32'd1103515245 + 32'd12345;
          sent++;
        end
      end
      c++;
    end
    i_valid = 1'b0;
    rand_mode = 1'b0;
    vectors++; if (recv != 1000) begin miscompares++; $display("FAIL random_count: got %0d want 1000", recv); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL random_leftover: got %0d want 0", sb.size()); end
    vectors++; if (bd_viol != 0) begin miscompares++; $display("FAIL random_bundled_data: got %0d violations want 0", bd_viol); end
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL random_err: got %b want 0", o_err); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_full();
    test_simul();
    test_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
